agex_stage: RTL and testbench
=============================

Name: agex_stage

Overview:
- Address-generation/execute stage, directly downstream of decode. Consumes the decode latch bundle.
- Computes the ALU result, memory address/store data, and branch/jump resolution.
- Runs MUL on an iterative shift-add unit, stalling decode while it works.
- Registers its results into the AGEX latch for the memory stage, and drives redirect to fetch and branch-resolved/stall to decode.

Parameters:
- DBITS, 32, datapath width
- REGNOBITS, 5, register index width
- IOPBITS, 6, internal opcode width (matches decode's op_I encoding; INVALID_I = 0)
- MUL_STEPS, 32, shift-add iterations per MUL (must equal DBITS)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- from_DE_latch  in  DE_latch_WIDTH  {inst, PC, pcplus, op_I, inst_count, rs1_val, rs2_val, rd, sxt_imm, bus_canary}
- from_AGEX_to_DE  out  2  {br_cond_AGEX, stall_AGEX}
- from_AGEX_to_FE  out  1+DBITS  {br_redirect_AGEX, br_target_AGEX}
- AGEX_latch_out  out  AGEX_latch_WIDTH  {inst, PC, op_I, inst_count, result, st_data, rd, wr_reg, is_load, is_store, bus_canary}

Behaviour:
- Reset (sync, active-high):
  - AGEX latch is all zeros; all outputs are 0.
  - FSM goes to IDLE; MUL counter, accumulator and operands are cleared.
  - Reset mid-MUL aborts the MUL with no result.
- Bubble: op_I == INVALID_I. The latch is written with all zeros (wr_reg = 0); no redirect.
- Single-cycle ops (latency 1; the latch is updated on the posedge after the input is presented):
  - ADD/SUB/AND/OR/XOR and their I-forms: operand2 = rs2_val for R-type, sxt_imm for I-type.
  - SLT/SLTI: signed compare. SLTU/SLTIU: unsigned compare. Result is 0 or 1.
  - SLL/SRL/SRA and their I-forms: shift amount = operand2[4:0]. SRA is arithmetic.
  - LUI: result = sxt_imm << 12.
  - AUIPC: result = PC + (sxt_imm << 12).
  - LW/SW: result = rs1_val + sxt_imm, 32-bit wrap-around.
    - LW: is_load = 1, wr_reg = 1.
    - SW: is_store = 1, st_data = rs2_val, wr_reg = 0.
  - CSRR: result = rs1_val pass-through, wr_reg = 1. CSRW: wr_reg = 0.
  - wr_reg = 1 for all ALU ops, LUI, AUIPC, LW, JAL and JALR; 0 for branches, SW and CSRW.
  - rd == 0 forces wr_reg = 0.
- Branches (BEQ/BNE/BLT/BGE signed; BLTU/BGEU unsigned) compare rs1_val with rs2_val.
  - Target = PC + (sxt_imm << 1).
- Jumps:
  - JAL: target = PC + (sxt_imm << 1).
  - JALR: target = (rs1_val + sxt_imm) & ~1.
  - Both: result = pcplus; always taken.
- Redirect timing:
  - br_redirect_AGEX and br_target_AGEX are registered together with the latch: a one-cycle pulse in the cycle after the branch enters.
  - br_cond_AGEX is asserted in the same cycle as br_redirect_AGEX, for every resolved branch/jump, taken or not, so decode releases its stall.
  - A not-taken branch gives br_redirect = 0 and br_cond = 1.
- MUL FSM (states IDLE, MUL_BUSY, MUL_DONE):
  - IDLE + MUL: capture operands, counter = 0, acc = 0; go to MUL_BUSY; stall_AGEX = 1 (combinational); latch written as a bubble.
  - MUL_BUSY: each cycle, if multiplier bit 0 is 1 then acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter++.
    - Stay while counter < MUL_STEPS-1; at counter == MUL_STEPS-1 go to MUL_DONE.
    - stall_AGEX = 1 throughout; latch holds bubbles.
  - MUL_DONE: latch gets the MUL entry (result = acc[DBITS-1:0], wr_reg = 1); stall_AGEX = 0; next state IDLE.
  - Total latency is MUL_STEPS+1 cycles from MUL entry to the latch.
  - While stalled, decode holds from_DE_latch stable and AGEX ignores it. The held MUL input is not re-captured in MUL_DONE.
  - A MUL is never accepted in the cycle of a redirect, since MUL never redirects.
- Canary: bus_canary passes through unchanged for valid ops.

Decomposition:
- Shared define.vh gets:
  - AGEX_latch_WIDTH
  - from_AGEX_to_DE_WIDTH (2)
  - from_AGEX_to_FE_WIDTH (DBITS+1)
  - the FSM state encodings
  - reuse of the existing op_I_* codes
- Sub-module agex_mul_iter contains:
  - the FSM, counter and shift-add datapath
  - ports: clk, reset, start, a, b, busy, done, product
- The top level holds the ALU, the branch unit and the latch.

Test Plan:
- ADDI, rs1_val = 0x7FFFFFFF, imm = 1: next cycle result = 0x80000000, wr_reg = 1, no redirect.
- SRA, rs1_val = 0x80000000, rs2_val = 0x21: result = 0xC0000000 (shamt 1). SRL with the same operands: result = 0x40000000.
- BNE, PC = 0x100, rs1_val = 1, rs2_val = 2, imm = 4: one-cycle pulse br_redirect = 1, target = 0x108, br_cond = 1. Same branch with rs2_val = 1: br_redirect = 0, br_cond = 1.
- JALR, rs1_val = 0x203, imm = 0, pcplus = 0x14: target = 0x202, result = 0x14, redirect pulse one cycle.
- MUL, rs1_val = 0xFFFFFFFF, rs2_val = 3:
  - stall_AGEX high for exactly 32 cycles; 31 bubbles plus the entry cycle's bubble enter the latch.
  - result = 0xFFFFFFFD on cycle 33.
  - Assert reset at cycle 10 of a second MUL: the next cycle has FSM IDLE, stall = 0, latch = 0.
- Bubble (all-zero DE latch), and ADD with rd = 0: latch all zeros / wr_reg = 0 respectively.

Source files
------------

// File: rtl/agex_pkg.sv
// Shared types and constants for the AGEX stage.
// Opcode values mirror decode's op_I encoding.
package agex_pkg;
  localparam int DBITS     = 32;
  localparam int REGNOBITS = 5;
  localparam int IOPBITS   = 6;
  localparam int MUL_STEPS = 32;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  localparam logic [IOPBITS-1:0] INVALID_I = 6'd0;
  localparam logic [IOPBITS-1:0] ADD_I     = 6'd1;
  localparam logic [IOPBITS-1:0] SUB_I     = 6'd2;
  localparam logic [IOPBITS-1:0] AND_I     = 6'd3;
  localparam logic [IOPBITS-1:0] OR_I      = 6'd4;
  localparam logic [IOPBITS-1:0] XOR_I     = 6'd5;
  localparam logic [IOPBITS-1:0] SLT_I     = 6'd6;
  localparam logic [IOPBITS-1:0] SLTU_I    = 6'd7;
  localparam logic [IOPBITS-1:0] SLL_I     = 6'd8;
  localparam logic [IOPBITS-1:0] SRL_I     = 6'd9;
  localparam logic [IOPBITS-1:0] SRA_I     = 6'd10;
  localparam logic [IOPBITS-1:0] ADDI_I    = 6'd11;
  localparam logic [IOPBITS-1:0] ANDI_I    = 6'd12;
  localparam logic [IOPBITS-1:0] ORI_I     = 6'd13;
  localparam logic [IOPBITS-1:0] XORI_I    = 6'd14;
  localparam logic [IOPBITS-1:0] SLTI_I    = 6'd15;
  localparam logic [IOPBITS-1:0] SLTIU_I   = 6'd16;
  localparam logic [IOPBITS-1:0] SLLI_I    = 6'd17;
  localparam logic [IOPBITS-1:0] SRLI_I    = 6'd18;
  localparam logic [IOPBITS-1:0] SRAI_I    = 6'd19;
  localparam logic [IOPBITS-1:0] LUI_I     = 6'd20;
  localparam logic [IOPBITS-1:0] AUIPC_I   = 6'd21;
  localparam logic [IOPBITS-1:0] LW_I      = 6'd22;
  localparam logic [IOPBITS-1:0] SW_I      = 6'd23;
  localparam logic [IOPBITS-1:0] BEQ_I     = 6'd24;
  localparam logic [IOPBITS-1:0] BNE_I     = 6'd25;
  localparam logic [IOPBITS-1:0] BLT_I     = 6'd26;
  localparam logic [IOPBITS-1:0] BGE_I     = 6'd27;
  localparam logic [IOPBITS-1:0] BLTU_I    = 6'd28;
  localparam logic [IOPBITS-1:0] BGEU_I    = 6'd29;
  localparam logic [IOPBITS-1:0] JAL_I     = 6'd30;
  localparam logic [IOPBITS-1:0] JALR_I    = 6'd31;
  localparam logic [IOPBITS-1:0] CSRR_I    = 6'd32;
  localparam logic [IOPBITS-1:0] CSRW_I    = 6'd33;
  localparam logic [IOPBITS-1:0] MUL_I     = 6'd34;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MUL_BUSY = 2'd1;
  localparam logic [1:0] S_MUL_DONE = 2'd2;

  typedef struct packed {
    logic [DBITS-1:0]     inst;
    logic [DBITS-1:0]     PC;
    logic [DBITS-1:0]     pcplus;
    logic [IOPBITS-1:0]   op_I;
    logic [DBITS-1:0]     inst_count;
    logic [DBITS-1:0]     rs1_val;
    logic [DBITS-1:0]     rs2_val;
    logic [REGNOBITS-1:0] rd;
    logic [DBITS-1:0]     sxt_imm;
    logic [DBITS-1:0]     bus_canary;
  } de_latch_t;

  typedef struct packed {
    logic [DBITS-1:0]     inst;
    logic [DBITS-1:0]     PC;
    logic [IOPBITS-1:0]   op_I;
    logic [DBITS-1:0]     inst_count;
    logic [DBITS-1:0]     result;
    logic [DBITS-1:0]     st_data;
    logic [REGNOBITS-1:0] rd;
    logic                 wr_reg;
    logic                 is_load;
    logic                 is_store;
    logic [DBITS-1:0]     bus_canary;
  } agex_latch_t;

  localparam int DE_latch_WIDTH        = $bits(de_latch_t);
  localparam int AGEX_latch_WIDTH      = $bits(agex_latch_t);
  localparam int from_AGEX_to_DE_WIDTH = 2;
  localparam int from_AGEX_to_FE_WIDTH = DBITS + 1;
endpackage

// File: rtl/agex_mul_iter.sv
// Iterative shift-add multiplier, low DBITS bits of the product.
// The final add step is folded into the DONE cycle output.
module agex_mul_iter
  import agex_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DBITS-1:0] a,
  input  logic [DBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DBITS-1:0] product
);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DBITS-1:0] r_mcand;
  logic [DBITS-1:0] r_mplier;
  logic [DBITS-1:0] r_acc;
  logic [DBITS-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL_BUSY;
          end
        end
        S_MUL_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          // counter reaches MUL_STEPS-1 on entry to DONE
          if (r_cnt == CNT_W'(MUL_STEPS - 2))
            r_state <= S_MUL_DONE;
        end
        S_MUL_DONE: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_MUL_BUSY);
  assign done    = (r_state == S_MUL_DONE);
  assign product = w_acc_nxt;
endmodule

// File: rtl/agex_stage.sv
// Execute / address-generation stage: ALU, branch unit, AGEX latch.
// MUL runs in agex_mul_iter while decode is stalled.
module agex_stage
  import agex_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DE_latch_WIDTH-1:0]        from_DE_latch,
  output logic [from_AGEX_to_DE_WIDTH-1:0] from_AGEX_to_DE,
  output logic [from_AGEX_to_FE_WIDTH-1:0] from_AGEX_to_FE,
  output logic [AGEX_latch_WIDTH-1:0]      AGEX_latch_out
);
  de_latch_t        w_de;
  agex_latch_t      w_nxt;
  agex_latch_t      r_latch;
  logic [DBITS-1:0] w_a;
  logic [DBITS-1:0] w_op2;
  logic [DBITS-1:0] w_res;
  logic [DBITS-1:0] w_tgt;
  logic [DBITS-1:0] w_prod;
  logic [4:0]       w_sh;
  logic             w_imm;
  logic             w_ok;
  logic             w_wr;
  logic             w_ld;
  logic             w_st;
  logic             w_br;
  logic             w_take;
  logic             w_start;
  logic             w_busy;
  logic             w_done;
  logic             w_iss;
  logic             r_redir;
  logic             r_cond;
  logic [DBITS-1:0] r_tgt;

  assign w_de  = from_DE_latch;
  assign w_a   = w_de.rs1_val;
  assign w_imm = w_de.op_I inside {ADDI_I, ANDI_I, ORI_I,
                                   XORI_I, SLTI_I, SLTIU_I,
                                   SLLI_I, SRLI_I, SRAI_I};
  assign w_op2 = w_imm ? w_de.sxt_imm : w_de.rs2_val;
  assign w_sh  = w_op2[4:0];

  always_comb begin
    w_res  = '0;
    w_ok   = 1'b1;
    w_wr   = 1'b0;
    w_ld   = 1'b0;
    w_st   = 1'b0;
    w_br   = 1'b0;
    w_take = 1'b0;
    w_tgt  = w_de.PC + (w_de.sxt_imm << 1);
    case (w_de.op_I)
      ADD_I, ADDI_I: begin w_res = w_a + w_op2; w_wr = 1'b1; end
      SUB_I:         begin w_res = w_a - w_op2; w_wr = 1'b1; end
      AND_I, ANDI_I: begin w_res = w_a & w_op2; w_wr = 1'b1; end
      OR_I, ORI_I:   begin w_res = w_a | w_op2; w_wr = 1'b1; end
      XOR_I, XORI_I: begin w_res = w_a ^ w_op2; w_wr = 1'b1; end
      SLT_I, SLTI_I: begin
        w_res = DBITS'($signed(w_a) < $signed(w_op2));
        w_wr  = 1'b1;
      end
      SLTU_I, SLTIU_I: begin
        w_res = DBITS'(w_a < w_op2);
        w_wr  = 1'b1;
      end
      SLL_I, SLLI_I: begin w_res = w_a << w_sh; w_wr = 1'b1; end
      SRL_I, SRLI_I: begin w_res = w_a >> w_sh; w_wr = 1'b1; end
      SRA_I, SRAI_I: begin
        w_res = $signed(w_a) >>> w_sh;
        w_wr  = 1'b1;
      end
      LUI_I: begin
        w_res = w_de.sxt_imm << 12;
        w_wr  = 1'b1;
      end
      AUIPC_I: begin
        w_res = w_de.PC + (w_de.sxt_imm << 12);
        w_wr  = 1'b1;
      end
      LW_I: begin
        w_res = w_a + w_de.sxt_imm;
        w_wr  = 1'b1;
        w_ld  = 1'b1;
      end
      SW_I: begin
        w_res = w_a + w_de.sxt_imm;
        w_st  = 1'b1;
      end
      BEQ_I:  begin w_br = 1'b1; w_take = w_a == w_de.rs2_val; end
      BNE_I:  begin w_br = 1'b1; w_take = w_a != w_de.rs2_val; end
      BLT_I:  begin
        w_br   = 1'b1;
        w_take = $signed(w_a) < $signed(w_de.rs2_val);
      end
      BGE_I:  begin
        w_br   = 1'b1;
        w_take = $signed(w_a) >= $signed(w_de.rs2_val);
      end
      BLTU_I: begin w_br = 1'b1; w_take = w_a < w_de.rs2_val; end
      BGEU_I: begin w_br = 1'b1; w_take = w_a >= w_de.rs2_val; end
      JAL_I: begin
        w_br   = 1'b1;
        w_take = 1'b1;
        w_res  = w_de.pcplus;
        w_wr   = 1'b1;
      end
      JALR_I: begin
        w_br   = 1'b1;
        w_take = 1'b1;
        w_res  = w_de.pcplus;
        w_wr   = 1'b1;
        w_tgt  = (w_a + w_de.sxt_imm) & ~DBITS'(1);
      end
      CSRR_I: begin w_res = w_a; w_wr = 1'b1; end
      CSRW_I: w_res = w_a;
      default: w_ok = 1'b0;
    endcase
  end

  // input is only consumed when the multiplier is idle
  assign w_start = (w_de.op_I == MUL_I) && !w_busy &&
                   !w_done && !reset;
  assign w_iss   = w_ok && !w_busy && !w_done;

  agex_mul_iter u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .a       (w_de.rs1_val),
    .b       (w_de.rs2_val),
    .busy    (w_busy),
    .done    (w_done),
    .product (w_prod)
  );

  always_comb begin
    w_nxt = '0;
    if (w_done || w_iss) begin
      w_nxt.inst       = w_de.inst;
      w_nxt.PC         = w_de.PC;
      w_nxt.op_I       = w_de.op_I;
      w_nxt.inst_count = w_de.inst_count;
      w_nxt.rd         = w_de.rd;
      w_nxt.bus_canary = w_de.bus_canary;
      w_nxt.result     = w_done ? w_prod : w_res;
      w_nxt.st_data    = w_st ? w_de.rs2_val : '0;
      w_nxt.wr_reg     = (w_done || w_wr) && (w_de.rd != '0);
      w_nxt.is_load    = w_iss && w_ld;
      w_nxt.is_store   = w_iss && w_st;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch <= '0;
      r_redir <= 1'b0;
      r_cond  <= 1'b0;
      r_tgt   <= '0;
    end else begin
      r_latch <= w_nxt;
      r_redir <= w_iss && w_br && w_take;
      r_cond  <= w_iss && w_br;
      r_tgt   <= (w_iss && w_br && w_take) ? w_tgt : '0;
    end
  end

  assign from_AGEX_to_DE = {r_cond, w_start || w_busy};
  assign from_AGEX_to_FE = {r_redir, r_tgt};
  assign AGEX_latch_out  = r_latch;
endmodule

// File: tb/tb_agex_stage.sv
// Directed-vector bench for agex_stage.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_agex_stage;
  import agex_pkg::*;

  logic        clk;
  logic        reset;
  de_latch_t   de_in;
  logic [1:0]  to_de;
  logic [32:0] to_fe;
  agex_latch_t lat;

  int n_vec = 0;
  int n_bad = 0;
  int n_st;
  int n_bub;

  localparam logic [31:0] CANARY = 32'hC0DE_CAFE;

  agex_stage u_dut (
    .clk             (clk),
    .reset           (reset),
    .from_DE_latch   (de_in),
    .from_AGEX_to_DE (to_de),
    .from_AGEX_to_FE (to_fe),
    .AGEX_latch_out  (lat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0]  op,
                       input logic [31:0] pc,
                       input logic [31:0] pcp,
                       input logic [31:0] r1,
                       input logic [31:0] r2,
                       input logic [4:0]  rd,
                       input logic [31:0] imm);
    de_latch_t d;
    d.inst       = 32'h0000_0013;
    d.PC         = pc;
    d.pcplus     = pcp;
    d.op_I       = op;
    d.inst_count = 32'd7;
    d.rs1_val    = r1;
    d.rs2_val    = r2;
    d.rd         = rd;
    d.sxt_imm    = imm;
    d.bus_canary = CANARY;
    de_in = d;
  endtask

  task automatic bubble();
    de_in = '0;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    de_in = '0;
    repeat (3) @(negedge clk);
    check("rst_latch", lat, '0);
    check("rst_de", to_de, 2'b00);
    check("rst_fe", to_fe, 33'd0);
    reset = 1'b0;

    drive(ADDI_I, 32'h0, 32'h4, 32'h7FFF_FFFF, 32'h0, 5'd3, 32'h1);
    @(negedge clk);
    check("addi_res", lat.result, 32'h8000_0000);
    check("addi_wr", lat.wr_reg, 1'b1);
    check("addi_redir", to_fe[32], 1'b0);
    check("addi_canary", lat.bus_canary, CANARY);

    drive(ADD_I, 32'h0, 32'h4, 32'h1, 32'h2, 5'd0, 32'h0);
    @(negedge clk);
    check("add_rd0_res", lat.result, 32'h3);
    check("add_rd0_wr", lat.wr_reg, 1'b0);

    drive(SRA_I, 32'h0, 32'h4, 32'h8000_0000, 32'h21, 5'd4, 32'h0);
    @(negedge clk);
    check("sra_res", lat.result, 32'hC000_0000);
    drive(SRL_I, 32'h0, 32'h4, 32'h8000_0000, 32'h21, 5'd4, 32'h0);
    @(negedge clk);
    check("srl_res", lat.result, 32'h4000_0000);

    drive(SLT_I, 32'h0, 32'h4, 32'hFFFF_FFFF, 32'h1, 5'd5, 32'h0);
    @(negedge clk);
    check("slt_res", lat.result, 32'h1);
    drive(SLTU_I, 32'h0, 32'h4, 32'hFFFF_FFFF, 32'h1, 5'd5, 32'h0);
    @(negedge clk);
    check("sltu_res", lat.result, 32'h0);

    drive(LUI_I, 32'h0, 32'h4, 32'h0, 32'h0, 5'd6, 32'h12345);
    @(negedge clk);
    check("lui_res", lat.result, 32'h1234_5000);
    drive(AUIPC_I, 32'h1000, 32'h1004, 32'h0, 32'h0, 5'd6, 32'h1);
    @(negedge clk);
    check("auipc_res", lat.result, 32'h2000);

    drive(LW_I, 32'h0, 32'h4, 32'hFFFF_FFF0, 32'h0, 5'd8, 32'h20);
    @(negedge clk);
    check("lw_addr", lat.result, 32'h10);
    check("lw_ld", lat.is_load, 1'b1);
    check("lw_wr", lat.wr_reg, 1'b1);
    drive(SW_I, 32'h0, 32'h4, 32'hFFFF_FFF0, 32'hDEAD_BEEF,
          5'd8, 32'h20);
    @(negedge clk);
    check("sw_addr", lat.result, 32'h10);
    check("sw_data", lat.st_data, 32'hDEAD_BEEF);
    check("sw_st", lat.is_store, 1'b1);
    check("sw_wr", lat.wr_reg, 1'b0);

    drive(BNE_I, 32'h100, 32'h104, 32'h1, 32'h2, 5'd0, 32'h4);
    @(negedge clk);
    check("bne_fe", to_fe, {1'b1, 32'h108});
    check("bne_cond", to_de[1], 1'b1);
    check("bne_wr", lat.wr_reg, 1'b0);
    bubble();
    @(negedge clk);
    check("bne_pulse", to_fe[32], 1'b0);
    check("bne_cond_off", to_de[1], 1'b0);
    check("bubble_latch", lat, '0);
    drive(BNE_I, 32'h100, 32'h104, 32'h1, 32'h1, 5'd0, 32'h4);
    @(negedge clk);
    check("bnent_redir", to_fe[32], 1'b0);
    check("bnent_cond", to_de[1], 1'b1);

    drive(JALR_I, 32'h10, 32'h14, 32'h203, 32'h0, 5'd1, 32'h0);
    @(negedge clk);
    check("jalr_fe", to_fe, {1'b1, 32'h202});
    check("jalr_res", lat.result, 32'h14);
    check("jalr_wr", lat.wr_reg, 1'b1);
    bubble();
    @(negedge clk);
    check("jalr_pulse", to_fe[32], 1'b0);

    drive(MUL_I, 32'h0, 32'h4, 32'hFFFF_FFFF, 32'h3, 5'd7, 32'h0);
    #1;
    n_st  = 0;
    n_bub = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0 && lat == '0) n_bub++;
      if (!to_de[0]) break;
      n_st++;
      @(negedge clk);
    end
    check("mul_stall_cyc", n_st, 32);
    check("mul_bubbles", n_bub, 32);
    @(negedge clk);
    check("mul_res", lat.result, 32'hFFFF_FFFD);
    check("mul_wr", lat.wr_reg, 1'b1);
    check("mul_rd", lat.rd, 5'd7);
    bubble();
    #1;
    check("mul_after_stall", to_de[0], 1'b0);

    @(negedge clk);
    drive(MUL_I, 32'h0, 32'h4, 32'h5, 32'h6, 5'd7, 32'h0);
    repeat (10) @(negedge clk);
    check("mul2_stall", to_de[0], 1'b1);
    reset = 1'b1;
    bubble();
    @(negedge clk);
    check("rstmul_busy", u_dut.u_mul.busy, 1'b0);
    check("rstmul_done", u_dut.u_mul.done, 1'b0);
    check("rstmul_stall", to_de, 2'b00);
    check("rstmul_latch", lat, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_latch", lat, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
